// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand bypass and load-use detection.
// Holds on EX stall and refreshes held operands from the write-back port.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 8
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] i_RS_Addr,
  input  logic [REG_ADDR_WIDTH-1:0] i_RT_Addr,
  input  logic [DATA_WIDTH-1:0]     i_RS_Data,
  input  logic [DATA_WIDTH-1:0]     i_RT_Data,
  input  logic [REG_ADDR_WIDTH-1:0] i_Dest_Addr,
  input  logic                      i_Reg_Write,
  input  logic                      i_Mem_Read,
  input  logic [DATA_WIDTH-1:0]     i_Imm,
  input  logic [CTRL_WIDTH-1:0]     i_Ctrl,
  input  logic [DATA_WIDTH-1:0]     i_PC,
  input  logic                      i_EXMEM_Reg_Write,
  input  logic [REG_ADDR_WIDTH-1:0] i_EXMEM_Dest_Addr,
  input  logic [DATA_WIDTH-1:0]     i_EXMEM_Result,
  input  logic                      i_MEMWB_Reg_Write,
  input  logic [REG_ADDR_WIDTH-1:0] i_MEMWB_Dest_Addr,
  input  logic [DATA_WIDTH-1:0]     i_MEMWB_Data,
  input  logic                      i_EX_Stall,
  input  logic                      i_Flush,
  output logic                      o_Stall_ID,
  output logic                      o_Valid,
  output logic [DATA_WIDTH-1:0]     o_RS_Data,
  output logic [DATA_WIDTH-1:0]     o_RT_Data,
  output logic [REG_ADDR_WIDTH-1:0] o_Dest_Addr,
  output logic                      o_Reg_Write,
  output logic                      o_Mem_Read,
  output logic [DATA_WIDTH-1:0]     o_Imm,
  output logic [CTRL_WIDTH-1:0]     o_Ctrl,
  output logic [DATA_WIDTH-1:0]     o_PC
);

  localparam logic [REG_ADDR_WIDTH-1:0] R0 = '0;

  logic [REG_ADDR_WIDTH-1:0] rs_q;
  logic [REG_ADDR_WIDTH-1:0] rt_q;
  logic [DATA_WIDTH-1:0]     rs_byp;
  logic [DATA_WIDTH-1:0]     rt_byp;
  logic                      load_use;
  logic                      rs_refresh;
  logic                      rt_refresh;

  // rs operand: r0, then youngest producer (EX/MEM), then MEM/WB, then regfile
  always_comb begin
    rs_byp = i_RS_Data;
    if (i_RS_Addr == R0)
      rs_byp = '0;
    else if (i_EXMEM_Reg_Write && i_EXMEM_Dest_Addr == i_RS_Addr)
      rs_byp = i_EXMEM_Result;
    else if (i_MEMWB_Reg_Write && i_MEMWB_Dest_Addr == i_RS_Addr)
      rs_byp = i_MEMWB_Data;
  end

  // rt operand: same priority as rs
  always_comb begin
    rt_byp = i_RT_Data;
    if (i_RT_Addr == R0)
      rt_byp = '0;
    else if (i_EXMEM_Reg_Write && i_EXMEM_Dest_Addr == i_RT_Addr)
      rt_byp = i_EXMEM_Result;
    else if (i_MEMWB_Reg_Write && i_MEMWB_Dest_Addr == i_RT_Addr)
      rt_byp = i_MEMWB_Data;
  end

  // hazard detection and write-back refresh of held operands
  always_comb begin
    load_use = o_Valid && o_Mem_Read && (o_Dest_Addr != R0) && i_Valid &&
               ((o_Dest_Addr == i_RS_Addr) || (o_Dest_Addr == i_RT_Addr));
    rs_refresh = i_MEMWB_Reg_Write && (rs_q != R0) &&
                 (i_MEMWB_Dest_Addr == rs_q);
    rt_refresh = i_MEMWB_Reg_Write && (rt_q != R0) &&
                 (i_MEMWB_Dest_Addr == rt_q);
    o_Stall_ID = i_EX_Stall || load_use;
  end

  // stage register: reset > flush > hold > bubble > capture
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Valid     <= 1'b0;
      o_Reg_Write <= 1'b0;
      o_Mem_Read  <= 1'b0;
      o_RS_Data   <= '0;
      o_RT_Data   <= '0;
      o_Dest_Addr <= '0;
      o_Imm       <= '0;
      o_Ctrl      <= '0;
      o_PC        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
    end else if (i_Flush) begin
      o_Valid     <= 1'b0;
      o_Reg_Write <= 1'b0;
      o_Mem_Read  <= 1'b0;
    end else if (i_EX_Stall) begin
      if (rs_refresh) o_RS_Data <= i_MEMWB_Data;
      if (rt_refresh) o_RT_Data <= i_MEMWB_Data;
    end else if (load_use) begin
      o_Valid     <= 1'b0;
      o_Reg_Write <= 1'b0;
      o_Mem_Read  <= 1'b0;
    end else begin
      o_Valid     <= i_Valid;
      o_Reg_Write <= i_Valid && i_Reg_Write;
      o_Mem_Read  <= i_Valid && i_Mem_Read;
      o_RS_Data   <= rs_byp;
      o_RT_Data   <= rt_byp;
      o_Dest_Addr <= i_Dest_Addr;
      o_Imm       <= i_Imm;
      o_Ctrl      <= i_Ctrl;
      o_PC        <= i_PC;
      rs_q        <= i_RS_Addr;
      rt_q        <= i_RT_Addr;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against
// an instruction-level reference model.
module tb_id_ex_stage;

  logic        i_Clk = 1'b0;
  logic        i_Reset, i_Valid;
  logic [4:0]  i_RS_Addr, i_RT_Addr, i_Dest_Addr;
  logic [31:0] i_RS_Data, i_RT_Data, i_Imm, i_PC;
  logic        i_Reg_Write, i_Mem_Read;
  logic [7:0]  i_Ctrl;
  logic        i_EXMEM_Reg_Write, i_MEMWB_Reg_Write;
  logic [4:0]  i_EXMEM_Dest_Addr, i_MEMWB_Dest_Addr;
  logic [31:0] i_EXMEM_Result, i_MEMWB_Data;
  logic        i_EX_Stall, i_Flush;
  logic        o_Stall_ID, o_Valid, o_Reg_Write, o_Mem_Read;
  logic [31:0] o_RS_Data, o_RT_Data, o_Imm, o_PC;
  logic [4:0]  o_Dest_Addr;
  logic [7:0]  o_Ctrl;

  int n_vec = 0;
  int n_err = 0;

  // expected pipeline-register contents
  logic        m_v, m_rw, m_mr;
  logic [4:0]  m_dest, m_rsa, m_rta;
  logic [31:0] m_rs, m_rt, m_imm, m_pc;
  logic [7:0]  m_ctrl;
  logic [31:0] imm_hold;

  id_ex_stage dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Valid(i_Valid),
    .i_RS_Addr(i_RS_Addr), .i_RT_Addr(i_RT_Addr),
    .i_RS_Data(i_RS_Data), .i_RT_Data(i_RT_Data),
    .i_Dest_Addr(i_Dest_Addr), .i_Reg_Write(i_Reg_Write),
    .i_Mem_Read(i_Mem_Read), .i_Imm(i_Imm), .i_Ctrl(i_Ctrl),
    .i_PC(i_PC),
    .i_EXMEM_Reg_Write(i_EXMEM_Reg_Write),
    .i_EXMEM_Dest_Addr(i_EXMEM_Dest_Addr),
    .i_EXMEM_Result(i_EXMEM_Result),
    .i_MEMWB_Reg_Write(i_MEMWB_Reg_Write),
    .i_MEMWB_Dest_Addr(i_MEMWB_Dest_Addr),
    .i_MEMWB_Data(i_MEMWB_Data),
    .i_EX_Stall(i_EX_Stall), .i_Flush(i_Flush),
    .o_Stall_ID(o_Stall_ID), .o_Valid(o_Valid),
    .o_RS_Data(o_RS_Data), .o_RT_Data(o_RT_Data),
    .o_Dest_Addr(o_Dest_Addr), .o_Reg_Write(o_Reg_Write),
    .o_Mem_Read(o_Mem_Read), .o_Imm(o_Imm), .o_Ctrl(o_Ctrl),
    .o_PC(o_PC)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // value a reader of register a sees right now
  function automatic logic [31:0] fwd(input logic [4:0] a,
                                      input logic [31:0] rf);
    if (a == 0) return 32'h0;
    if (i_EXMEM_Reg_Write && i_EXMEM_Dest_Addr == a) return i_EXMEM_Result;
    if (i_MEMWB_Reg_Write && i_MEMWB_Dest_Addr == a) return i_MEMWB_Data;
    return rf;
  endfunction

  // compare everything, then advance the model across one edge
  task automatic cyc();
    logic lu;
    @(negedge i_Clk);
    lu = m_v && m_mr && m_dest != 0 && i_Valid &&
         (m_dest == i_RS_Addr || m_dest == i_RT_Addr);
    chk("valid", {31'b0, o_Valid}, {31'b0, m_v});
    chk("regwr", {31'b0, o_Reg_Write}, {31'b0, m_rw});
    chk("memrd", {31'b0, o_Mem_Read}, {31'b0, m_mr});
    chk("rs", o_RS_Data, m_rs);
    chk("rt", o_RT_Data, m_rt);
    chk("dest", {27'b0, o_Dest_Addr}, {27'b0, m_dest});
    chk("imm", o_Imm, m_imm);
    chk("ctrl", {24'b0, o_Ctrl}, {24'b0, m_ctrl});
    chk("pc", o_PC, m_pc);
    chk("stall", {31'b0, o_Stall_ID}, {31'b0, i_EX_Stall | lu});
    if (i_Reset) begin
      {m_v, m_rw, m_mr} = 3'b0;
      m_dest = 0; m_rsa = 0; m_rta = 0;
      m_rs = 0; m_rt = 0; m_imm = 0; m_pc = 0; m_ctrl = 0;
    end else if (i_Flush || (!i_EX_Stall && lu)) begin
      {m_v, m_rw, m_mr} = 3'b0;
    end else if (i_EX_Stall) begin
      if (i_MEMWB_Reg_Write && m_rsa != 0 && i_MEMWB_Dest_Addr == m_rsa)
        m_rs = i_MEMWB_Data;
      if (i_MEMWB_Reg_Write && m_rta != 0 && i_MEMWB_Dest_Addr == m_rta)
        m_rt = i_MEMWB_Data;
    end else begin
      m_v = i_Valid;
      m_rw = i_Valid & i_Reg_Write;
      m_mr = i_Valid & i_Mem_Read;
      m_rs = fwd(i_RS_Addr, i_RS_Data);
      m_rt = fwd(i_RT_Addr, i_RT_Data);
      m_dest = i_Dest_Addr; m_rsa = i_RS_Addr; m_rta = i_RT_Addr;
      m_imm = i_Imm; m_ctrl = i_Ctrl; m_pc = i_PC;
    end
    @(posedge i_Clk);
    #1;
  endtask

  task automatic rnd();
    i_Valid = ($urandom_range(0, 4) != 0);
    i_RS_Addr = 5'($urandom_range(0, 3));
    i_RT_Addr = 5'($urandom_range(0, 3));
    i_Dest_Addr = 5'($urandom_range(0, 3));
    i_RS_Data = $urandom; i_RT_Data = $urandom;
    i_Reg_Write = 1'($urandom); i_Mem_Read = ($urandom_range(0, 2) == 0);
    i_Imm = $urandom; i_PC = $urandom; i_Ctrl = 8'($urandom);
    i_EXMEM_Reg_Write = 1'($urandom);
    i_EXMEM_Dest_Addr = 5'($urandom_range(0, 3));
    i_EXMEM_Result = $urandom;
    i_MEMWB_Reg_Write = 1'($urandom);
    i_MEMWB_Dest_Addr = 5'($urandom_range(0, 3));
    i_MEMWB_Data = $urandom;
    i_EX_Stall = ($urandom_range(0, 4) == 0);
    i_Flush = ($urandom_range(0, 9) == 0);
    i_Reset = ($urandom_range(0, 49) == 0);
  endtask

  task automatic quiet();
    rnd();
    i_Reset = 0; i_Flush = 0; i_EX_Stall = 0;
    i_Mem_Read = 0; i_EXMEM_Reg_Write = 0; i_MEMWB_Reg_Write = 0;
  endtask

  initial begin
    {m_v, m_rw, m_mr} = 3'b0;
    m_dest = 0; m_rsa = 0; m_rta = 0;
    m_rs = 0; m_rt = 0; m_imm = 0; m_pc = 0; m_ctrl = 0;

    // reset held two cycles with random inputs
    rnd(); i_Reset = 1;
    @(posedge i_Clk); #1;
    rnd(); i_Reset = 1;
    cyc();
    quiet(); i_Valid = 1;
    #1;
    chk("rst_valid", {31'b0, o_Valid}, 32'd0);
    chk("rst_rs", o_RS_Data, 32'd0);
    chk("rst_stall", {31'b0, o_Stall_ID}, 32'd0);

    // bypass priority
    quiet(); i_Valid = 1; i_RS_Addr = 5; i_RS_Data = 32'h1111;
    i_EXMEM_Reg_Write = 1; i_EXMEM_Dest_Addr = 5;
    i_EXMEM_Result = 32'hAAAA;
    i_MEMWB_Reg_Write = 1; i_MEMWB_Dest_Addr = 5;
    i_MEMWB_Data = 32'hBBBB;
    cyc();
    chk("byp_exmem", o_RS_Data, 32'hAAAA);
    i_EXMEM_Reg_Write = 0;
    cyc();
    chk("byp_memwb", o_RS_Data, 32'hBBBB);
    i_EXMEM_Reg_Write = 1; i_RS_Addr = 0;
    i_EXMEM_Dest_Addr = 0; i_MEMWB_Dest_Addr = 0;
    cyc();
    chk("byp_r0", o_RS_Data, 32'h0);

    // load-use on rt
    quiet(); i_Valid = 1; i_Mem_Read = 1; i_Reg_Write = 1;
    i_Dest_Addr = 7; i_RS_Addr = 0; i_RT_Addr = 0;
    cyc();
    quiet(); i_Valid = 1; i_RS_Addr = 1; i_RT_Addr = 7;
    i_RT_Data = 32'h2222;
    #1;
    chk("lu_stall", {31'b0, o_Stall_ID}, 32'd1);
    cyc();
    chk("lu_bubble", {31'b0, o_Valid}, 32'd0);
    i_MEMWB_Reg_Write = 1; i_MEMWB_Dest_Addr = 7;
    i_MEMWB_Data = 32'hCAFE;
    #1;
    chk("lu_once", {31'b0, o_Stall_ID}, 32'd0);
    cyc();
    chk("lu_valid", {31'b0, o_Valid}, 32'd1);
    chk("lu_rt", o_RT_Data, 32'hCAFE);

    // EX stall with write-back refresh of held rs
    quiet(); i_Valid = 1; i_RS_Addr = 3; i_RS_Data = 32'h5555;
    imm_hold = i_Imm;
    cyc();
    for (int k = 0; k < 3; k++) begin
      i_EX_Stall = 1; i_Imm = $urandom; i_RS_Addr = 5'($urandom);
      i_MEMWB_Reg_Write = 1; i_MEMWB_Dest_Addr = 3;
      i_MEMWB_Data = 32'h1234;
      #1;
      chk("hold_stall", {31'b0, o_Stall_ID}, 32'd1);
      cyc();
      chk("hold_rs", o_RS_Data, 32'h1234);
      chk("hold_imm", o_Imm, imm_hold);
    end

    // flush beats stall
    quiet(); i_Valid = 1;
    cyc();
    i_Flush = 1; i_EX_Stall = 1;
    cyc();
    chk("flush_valid", {31'b0, o_Valid}, 32'd0);
    chk("flush_regwr", {31'b0, o_Reg_Write}, 32'd0);
    chk("flush_memrd", {31'b0, o_Mem_Read}, 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rnd();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
